// File: rtl/pipe_sched.sv
// pipe_sched -- pipeline stall/flush scheduler for the 5-stage LEGv8 core.
//
// This block merges four requests into one prioritised set of enables and
// flushes for the pipeline registers:
//   - the hazard-detection result
//   - the MEM-stage branch decision
//   - the data-memory handshake
//   - a HALT decoded in ID
// After a HALT it drains the pipeline, then holds the core until resume.
//
// Optional feature: define PERF_CNT_EN to build the stall and flush
// performance counters. When it is undefined, both counter ports read 0.
//
// Parameters:
//   CNT_W      width of the performance counters
//   DRAIN_CYC  cycles from HALT leaving ID until it retires from WB (1..3)
//
// Ports:
//   clk           rising-edge clock
//   reset         asynchronous, active-low reset
//   hd_enable     hazard-detection result, 0 = load-use stall needed
//   branch_taken  PCSrc from the MEM stage
//   mem_req       MEM stage accesses data memory this cycle
//   mem_ack       data memory completes the access this cycle
//   halt_id       HALT decoded in the ID stage
//   resume        leave the HALTED state
//   pc_write      PC register load enable
//   if_id_write   IF/ID load enable
//   if_id_flush   zero the IF/ID instruction
//   id_ex_bubble  zero the control fields entering ID/EX
//   ex_mem_flush  zero the control fields entering EX/MEM
//   pipe_en       load enable for ID/EX, EX/MEM and MEM/WB
//   halted        core halted
//   stall_cycles  count of load-use stall cycles
//   flush_events  count of taken-branch flushes
module pipe_sched #(
  parameter int CNT_W     = 32,
  parameter int DRAIN_CYC = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             hd_enable,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ack,
  input  logic             halt_id,
  input  logic             resume,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             ex_mem_flush,
  output logic             pipe_en,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_state_next;
  logic [1:0] r_drain_cnt;
  logic [1:0] w_drain_cnt_next;
  logic       w_freeze;

  // A pending data-memory access stalls the whole pipeline.
  assign w_freeze = mem_req & ~mem_ack;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_RUN;
      r_drain_cnt <= 2'd0;
    end else begin
      r_state     <= w_state_next;
      r_drain_cnt <= w_drain_cnt_next;
    end
  end

  always_comb begin
    pc_write         = 1'b1;
    if_id_write      = 1'b1;
    if_id_flush      = 1'b0;
    id_ex_bubble     = 1'b0;
    ex_mem_flush     = 1'b0;
    pipe_en          = 1'b1;
    halted           = 1'b0;
    w_state_next     = r_state;
    w_drain_cnt_next = r_drain_cnt;

    case (r_state)
      ST_RUN: begin
        if (w_freeze) begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          pipe_en     = 1'b0;
        end else if (branch_taken) begin
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
          ex_mem_flush = 1'b1;
        end else if (!hd_enable) begin
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          id_ex_bubble = 1'b1;
        end else if (halt_id) begin
          pc_write         = 1'b0;
          if_id_write      = 1'b0;
          w_state_next     = ST_DRAIN;
          w_drain_cnt_next = 2'(DRAIN_CYC);
        end
      end

      ST_DRAIN: begin
        // IF/ID keeps loading zeros behind the HALT, so nothing younger
        // than the HALT can enter the pipeline.
        pc_write    = 1'b0;
        if_id_flush = 1'b1;
        if (w_freeze) begin
          pipe_en = 1'b0;
        end else if (branch_taken) begin
          // An older branch cancels the HALT, so normal fetch resumes.
          pc_write     = 1'b1;
          id_ex_bubble = 1'b1;
          ex_mem_flush = 1'b1;
          w_state_next = ST_RUN;
        end else if (r_drain_cnt <= 2'd1) begin
          w_drain_cnt_next = 2'd0;
          w_state_next     = ST_HALTED;
        end else begin
          w_drain_cnt_next = r_drain_cnt - 2'd1;
        end
      end

      ST_HALTED: begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        pipe_en     = 1'b0;
        halted      = 1'b1;
        if (resume) begin
          w_state_next = ST_RUN;
        end
      end

      default: begin
        w_state_next     = ST_RUN;
        w_drain_cnt_next = 2'd0;
      end
    endcase

    // While reset is held, every output is driven low, whatever the state.
    if (!reset) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_bubble = 1'b0;
      ex_mem_flush = 1'b0;
      pipe_en      = 1'b0;
      halted       = 1'b0;
    end
  end

`ifdef PERF_CNT_EN
  logic             w_stall_evt;
  logic             w_flush_evt;
  logic [CNT_W-1:0] r_stall_cycles;
  logic [CNT_W-1:0] r_flush_events;

  // Load-use stalls are counted only when they win in RUN. A branch flush
  // is counted in RUN or DRAIN whenever no freeze masks it.
  assign w_stall_evt = (r_state == ST_RUN) & ~w_freeze & ~branch_taken & ~hd_enable;
  assign w_flush_evt = ((r_state == ST_RUN) | (r_state == ST_DRAIN)) & ~w_freeze & branch_taken;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cycles <= '0;
      r_flush_events <= '0;
    end else begin
      if (w_stall_evt) r_stall_cycles <= r_stall_cycles + 1'b1;
      if (w_flush_evt) r_flush_events <= r_flush_events + 1'b1;
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign flush_events = r_flush_events;
`else
  assign stall_cycles = '0;
  assign flush_events = '0;
`endif

endmodule

// File: tb/tb_pipe_sched.sv
module tb_pipe_sched;

  localparam int CNT_W = 32;

`ifdef PERF_CNT_EN
  localparam bit PC_ON = 1'b1;
`else
  localparam bit PC_ON = 1'b0;
`endif

  logic             clk;
  logic             reset;
  logic             hd_enable;
  logic             branch_taken;
  logic             mem_req;
  logic             mem_ack;
  logic             halt_id;
  logic             resume;
  logic             pc_write;
  logic             if_id_write;
  logic             if_id_flush;
  logic             id_ex_bubble;
  logic             ex_mem_flush;
  logic             pipe_en;
  logic             halted;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_events;

  int n_cmp;
  int n_err;
  int exp_stall;
  int exp_flush;

  pipe_sched #(.CNT_W(CNT_W), .DRAIN_CYC(3)) dut (
    .clk          (clk),
    .reset        (reset),
    .hd_enable    (hd_enable),
    .branch_taken (branch_taken),
    .mem_req      (mem_req),
    .mem_ack      (mem_ack),
    .halt_id      (halt_id),
    .resume       (resume),
    .pc_write     (pc_write),
    .if_id_write  (if_id_write),
    .if_id_flush  (if_id_flush),
    .id_ex_bubble (id_ex_bubble),
    .ex_mem_flush (ex_mem_flush),
    .pipe_en      (pipe_en),
    .halted       (halted),
    .stall_cycles (stall_cycles),
    .flush_events (flush_events)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp, $time);
    end else begin
      $display("ok   %s = %0h", tag, obs);
    end
  endtask

  // Apply inputs 1ns after the rising edge, then let them settle.
  task automatic drive(input logic hd, input logic br, input logic rq,
                       input logic ak, input logic ht, input logic rs);
    hd_enable    = hd;
    branch_taken = br;
    mem_req      = rq;
    mem_ack      = ak;
    halt_id      = ht;
    resume       = rs;
    #2;
  endtask

  task automatic next_cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cnt(input string tag);
    chk({tag, ".stall"}, stall_cycles, PC_ON ? 32'(exp_stall) : 32'd0);
    chk({tag, ".flush"}, flush_events, PC_ON ? 32'(exp_flush) : 32'd0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    exp_stall = 0;
    exp_flush = 0;
    reset = 1'b0;
    drive(1, 0, 0, 0, 0, 0);

    // ---- reset state ----
    chk("rst.pc_write", pc_write, 1'b0);
    chk("rst.pipe_en", pipe_en, 1'b0);
    chk("rst.halted", halted, 1'b0);
    next_cyc();
    next_cyc();
    reset = 1'b1;
    drive(1, 0, 0, 0, 0, 0);
    chk("idle.pc_write", pc_write, 1'b1);
    chk("idle.if_id_write", if_id_write, 1'b1);
    chk("idle.pipe_en", pipe_en, 1'b1);
    chk("idle.flushes", {if_id_flush, id_ex_bubble, ex_mem_flush}, 3'b000);
    chk_cnt("idle");

    // ---- one-cycle load-use stall ----
    next_cyc();
    drive(0, 0, 0, 0, 0, 0);
    chk("stall.pc_write", pc_write, 1'b0);
    chk("stall.if_id_write", if_id_write, 1'b0);
    chk("stall.bubble", id_ex_bubble, 1'b1);
    chk("stall.pipe_en", pipe_en, 1'b1);
    exp_stall++;
    next_cyc();
    drive(1, 0, 0, 0, 0, 0);
    chk("poststall.pc_write", pc_write, 1'b1);
    chk("poststall.bubble", id_ex_bubble, 1'b0);
    chk_cnt("poststall");

    // ---- four-cycle freeze that masks a branch ----
    for (int i = 0; i < 4; i++) begin
      next_cyc();
      drive(1, 1, 1, 0, 0, 0);
      chk($sformatf("frz%0d.pipe_en", i), pipe_en, 1'b0);
      chk($sformatf("frz%0d.pc_write", i), pc_write, 1'b0);
      chk($sformatf("frz%0d.flushes", i), {if_id_flush, id_ex_bubble, ex_mem_flush}, 3'b000);
    end
    next_cyc();
    drive(1, 0, 1, 1, 0, 0);
    chk("ack.pipe_en", pipe_en, 1'b1);
    chk("ack.pc_write", pc_write, 1'b1);
    chk("ack.flushes", {if_id_flush, id_ex_bubble, ex_mem_flush}, 3'b000);
    chk_cnt("ack");

    // ---- branch beats load-use stall ----
    next_cyc();
    drive(0, 1, 0, 0, 0, 0);
    chk("br.flushes", {if_id_flush, id_ex_bubble, ex_mem_flush}, 3'b111);
    chk("br.pc_write", pc_write, 1'b1);
    chk("br.if_id_write", if_id_write, 1'b1);
    exp_flush++;
    next_cyc();
    drive(1, 0, 0, 0, 0, 0);
    chk_cnt("postbr");

    // ---- HALT, drain of 3 cycles, HALTED, then resume ----
    next_cyc();
    drive(1, 0, 0, 0, 1, 0);
    chk("halt.pc_write", pc_write, 1'b0);
    chk("halt.if_id_write", if_id_write, 1'b0);
    chk("halt.halted", halted, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      next_cyc();
      drive(1, 0, 0, 0, 0, 0);
      chk($sformatf("drn%0d.pc_write", i), pc_write, 1'b0);
      chk($sformatf("drn%0d.if_id_flush", i), if_id_flush, 1'b1);
      chk($sformatf("drn%0d.pipe_en", i), pipe_en, 1'b1);
      chk($sformatf("drn%0d.halted", i), halted, 1'b0);
    end
    // Inputs other than resume must be ignored while halted.
    for (int i = 0; i < 3; i++) begin
      next_cyc();
      drive(0, 1, 1, 0, 1, 0);
      chk($sformatf("hlt%0d.halted", i), halted, 1'b1);
      chk($sformatf("hlt%0d.ctl", i), {pc_write, if_id_write, pipe_en}, 3'b000);
      chk($sformatf("hlt%0d.flushes", i), {if_id_flush, id_ex_bubble, ex_mem_flush}, 3'b000);
    end
    next_cyc();
    drive(1, 0, 0, 0, 0, 1);
    chk("resume.halted", halted, 1'b1);
    chk_cnt("halted");
    next_cyc();
    drive(1, 0, 0, 0, 0, 0);
    chk("run.halted", halted, 1'b0);
    chk("run.pc_write", pc_write, 1'b1);

    // ---- branch in the first drain cycle cancels the HALT ----
    next_cyc();
    drive(1, 0, 0, 0, 1, 0);
    next_cyc();
    drive(1, 1, 0, 0, 0, 0);
    chk("drnbr.flushes", {if_id_flush, id_ex_bubble, ex_mem_flush}, 3'b111);
    chk("drnbr.pc_write", pc_write, 1'b1);
    exp_flush++;
    for (int i = 0; i < 4; i++) begin
      next_cyc();
      drive(1, 0, 0, 0, 0, 0);
      chk($sformatf("cancel%0d.halted", i), halted, 1'b0);
      chk($sformatf("cancel%0d.pc_write", i), pc_write, 1'b1);
    end
    chk_cnt("cancel");

    // ---- freeze during drain holds the drain count ----
    next_cyc();
    drive(1, 0, 0, 0, 1, 0);
    next_cyc();
    drive(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      next_cyc();
      drive(1, 0, 1, 0, 0, 0);
      chk($sformatf("drnfrz%0d.pipe_en", i), pipe_en, 1'b0);
      chk($sformatf("drnfrz%0d.pc_write", i), pc_write, 1'b0);
    end
    next_cyc();
    drive(1, 0, 0, 0, 0, 0);
    chk("drnfrz.c4.halted", halted, 1'b0);
    next_cyc();
    drive(1, 0, 0, 0, 0, 0);
    chk("drnfrz.c5.halted", halted, 1'b0);
    next_cyc();
    drive(1, 0, 0, 0, 0, 1);
    chk("drnfrz.c6.halted", halted, 1'b1);
    next_cyc();
    drive(1, 0, 0, 0, 0, 0);
    chk("drnfrz.run.pc_write", pc_write, 1'b1);

    // ---- asynchronous reset mid-drain ----
    next_cyc();
    drive(1, 0, 0, 0, 1, 0);
    next_cyc();
    drive(1, 0, 0, 0, 0, 0);
    chk("prerst.if_id_flush", if_id_flush, 1'b1);
    reset = 1'b0;
    #1;
    chk("arst.ctl", {pc_write, if_id_write, pipe_en, halted}, 4'b0000);
    chk("arst.flushes", {if_id_flush, id_ex_bubble, ex_mem_flush}, 3'b000);
    exp_stall = 0;
    exp_flush = 0;
    chk_cnt("arst");
    next_cyc();
    reset = 1'b1;
    drive(1, 0, 0, 0, 0, 0);
    chk("postrst.pc_write", pc_write, 1'b1);
    chk("postrst.if_id_flush", if_id_flush, 1'b0);
    chk("postrst.halted", halted, 1'b0);
    chk_cnt("postrst");
    next_cyc();
    drive(1, 0, 0, 0, 0, 0);
    chk("postrst2.pc_write", pc_write, 1'b1);
    chk("postrst2.if_id_flush", if_id_flush, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
